// File: rtl/drive_pkg.sv
// Shared drive-controller definitions: one-hot drive state encodings and
// the bit positions inside the move_cmd bus.
package drive_pkg;

    // One-hot drive states
    localparam logic [3:0] ST_UNSTARTING = 4'b0001;
    localparam logic [3:0] ST_STARTING   = 4'b0010;
    localparam logic [3:0] ST_MOVING     = 4'b0100;
    localparam logic [3:0] ST_POWER_OFF  = 4'b1000;

    // move_cmd bit indices
    localparam int MV_FWD   = 0;
    localparam int MV_REV   = 1;
    localparam int MV_LEFT  = 2;
    localparam int MV_RIGHT = 3;

    // Turn lamps may only blink while the drive is starting or moving;
    // any other value, including a non-one-hot code, keeps them dark.
    function automatic logic lamp_state(input logic [3:0] s);
        return (s == ST_STARTING) || (s == ST_MOVING);
    endfunction

endpackage

// File: rtl/bcd4_counter.sv
// Four-digit BCD up-counter with enable and synchronous clear.
// Each digit rolls 9 -> 0 and carries; 9999 wraps to 0000.
module bcd4_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    output logic [15:0] count
);

    logic [15:0] inc_val;
    logic        carry;

    // Ripple a +1 through the digits, stopping at the first digit below 9
    always_comb begin
        inc_val = count;
        carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (count[i*4 +: 4] >= 4'd9) begin
                    inc_val[i*4 +: 4] = 4'd0;
                end else begin
                    inc_val[i*4 +: 4] = count[i*4 +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // Count register: clear has priority over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 16'h0000;
        end else if (clr) begin
            count <= 16'h0000;
        end else if (en) begin
            count <= inc_val;
        end
    end

endmodule

// File: rtl/motion_indicator.sv
// Turn-lamp blinker, forced-off fault latch and optional BCD odometer.
// Define ODOMETER_EN to build the odometer; without it mileage is tied
// to zero and no mileage logic exists.
module motion_indicator
    import drive_pkg::*;
#(
    parameter int BLINK_DIV = 50_000_000,
    parameter int MILE_DIV  = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  state,
    input  logic [3:0]  move_cmd,
    input  logic        change,
    output logic        led_left,
    output logic        led_right,
    output logic        fault,
    output logic [15:0] mileage
);

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_cnt;
    logic          phase;
    logic          phase_next;
    logic          turn_d;
    logic          turn_req;
    logic          turn_rise;
    logic          blink_tc;

    assign turn_req  = move_cmd[MV_LEFT] | move_cmd[MV_RIGHT];
    assign turn_rise = turn_req & ~turn_d;
    assign blink_tc  = (blink_cnt == BW'(BLINK_DIV - 1));

    // Next blink phase: a fresh turn request restarts lit, else toggle on terminal count
    always_comb begin
        phase_next = phase;
        if (turn_rise) begin
            phase_next = 1'b1;
        end else if (blink_tc) begin
            phase_next = ~phase;
        end
    end

    // Blink prescaler, phase and turn-request edge detector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
            turn_d    <= 1'b0;
        end else begin
            turn_d <= turn_req;
            phase  <= phase_next;
            if (turn_rise || blink_tc) begin
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // Registered lamps use the upcoming phase so a new request lights next cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_left  <= 1'b0;
            led_right <= 1'b0;
        end else begin
            led_left  <= lamp_state(state) & move_cmd[MV_LEFT]  & phase_next;
            led_right <= lamp_state(state) & move_cmd[MV_RIGHT] & phase_next;
        end
    end

    // Fault latch: a forced-off event sets it, returning to unstarting clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault <= 1'b0;
        end else if (change) begin
            fault <= 1'b1;
        end else if (state == ST_UNSTARTING) begin
            fault <= 1'b0;
        end
    end

`ifdef ODOMETER_EN
    localparam int MW = (MILE_DIV > 1) ? $clog2(MILE_DIV) : 1;

    logic [MW-1:0] mile_cnt;
    logic          mile_run;
    logic          mile_clr;
    logic          mile_tc;

    assign mile_run = (state == ST_MOVING) & (move_cmd[MV_FWD] | move_cmd[MV_REV]);
    assign mile_clr = (state == ST_POWER_OFF);
    assign mile_tc  = (mile_cnt == MW'(MILE_DIV - 1));

    // Mileage prescaler: cleared at power-off, advances only while in motion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mile_cnt <= '0;
        end else if (mile_clr) begin
            mile_cnt <= '0;
        end else if (mile_run) begin
            if (mile_tc) begin
                mile_cnt <= '0;
            end else begin
                mile_cnt <= mile_cnt + MW'(1);
            end
        end
    end

    bcd4_counter u_odo (
        .clk   (clk),
        .rst   (rst),
        .en    (mile_run & mile_tc),
        .clr   (mile_clr),
        .count (mileage)
    );
`else
    // Motion bits only feed the odometer, which is absent in this build
    logic unused_motion;
    assign unused_motion = move_cmd[MV_FWD] ^ move_cmd[MV_REV];
    assign mileage       = 16'h0000;
`endif

endmodule

// File: tb/tb_motion_indicator.sv
// Self-checking bench for motion_indicator with BLINK_DIV=4, MILE_DIV=8.
// The reference model tracks elapsed cycles since the last blink origin and
// the odometer as a plain decimal integer.
module tb_motion_indicator;

    localparam int BLINK_DIV = 4;
    localparam int MILE_DIV  = 8;

`ifdef ODOMETER_EN
    localparam bit ODO = 1'b1;
`else
    localparam bit ODO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  state;
    logic [3:0]  move_cmd;
    logic        change;
    logic        led_left;
    logic        led_right;
    logic        fault;
    logic [15:0] mileage;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    int m_e;          // edges since blink origin
    int m_o;          // origin offset: 1 after reset, BLINK_DIV after a turn restart
    bit m_prev_turn;
    bit m_left;
    bit m_right;
    bit m_fault;
    int m_miles;      // odometer as decimal 0..9999
    int m_ticks;      // motion cycles toward next mile

    // Clock
    always #5 clk = ~clk;

    motion_indicator #(
        .BLINK_DIV (BLINK_DIV),
        .MILE_DIV  (MILE_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .move_cmd  (move_cmd),
        .change    (change),
        .led_left  (led_left),
        .led_right (led_right),
        .fault     (fault),
        .mileage   (mileage)
    );

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_e         = -1;
        m_o         = 1;
        m_prev_turn = 1'b0;
        m_left      = 1'b0;
        m_right     = 1'b0;
        m_fault     = 1'b0;
        m_miles     = 0;
        m_ticks     = 0;
    endtask

    // One clock edge of behaviour, using the inputs currently applied
    task automatic model_edge();
        bit turn;
        bit ph;
        bit lit_ok;
        turn = move_cmd[2] | move_cmd[3];
        if (turn && !m_prev_turn) begin
            m_e = 0;
            m_o = BLINK_DIV;
        end else begin
            m_e++;
        end
        m_prev_turn = turn;
        ph      = (((m_e + m_o) / BLINK_DIV) % 2) == 1;
        lit_ok  = (state == 4'b0010) || (state == 4'b0100);
        m_left  = lit_ok && move_cmd[2] && ph;
        m_right = lit_ok && move_cmd[3] && ph;
        if (change) m_fault = 1'b1;
        else if (state == 4'b0001) m_fault = 1'b0;
        if (state == 4'b1000) begin
            m_miles = 0;
            m_ticks = 0;
        end else if (state == 4'b0100 && (move_cmd[0] || move_cmd[1])) begin
            m_ticks++;
            if (m_ticks == MILE_DIV) begin
                m_ticks = 0;
                m_miles = (m_miles + 1) % 10000;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".led_left"},  16'(led_left),  16'(m_left));
        check_eq({tag, ".led_right"}, 16'(led_right), 16'(m_right));
        check_eq({tag, ".fault"},     16'(fault),     16'(m_fault));
        check_eq({tag, ".mileage"},   mileage,        ODO ? to_bcd(m_miles) : 16'h0000);
    endtask

    task automatic step(input bit chk);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (chk) check_all("cyc");
    endtask

    task automatic run(input int n, input bit chk);
        for (int i = 0; i < n; i++) step(chk);
    endtask

    initial begin
        rst      = 1'b0;
        state    = 4'b0001;
        move_cmd = 4'b0000;
        change   = 1'b0;
        model_reset();
        #12;
        check_eq("reset.led_left",  16'(led_left),  16'h0);
        check_eq("reset.led_right", 16'(led_right), 16'h0);
        check_eq("reset.fault",     16'(fault),     16'h0);
        check_eq("reset.mileage",   mileage,        16'h0000);

        // Left blink from reset while starting
        @(negedge clk);
        rst      = 1'b1;
        state    = 4'b0010;
        move_cmd = 4'b0100;
        step(1);
        check_eq("blink.first_lit", 16'(led_left), 16'h1);
        run(19, 1);

        // 80 moving cycles = 10 miles, then hold while starting
        state    = 4'b0100;
        move_cmd = 4'b0001;
        run(80, 1);
        check_eq("odo.after80", mileage, ODO ? 16'h0010 : 16'h0000);
        state = 4'b0010;
        run(20, 1);
        check_eq("odo.hold_starting", mileage, ODO ? 16'h0010 : 16'h0000);

        // Illegal state: lamps dark, mileage holds
        state    = 4'b0110;
        move_cmd = 4'b1000;
        run(10, 1);
        check_eq("illegal.led_right", 16'(led_right), 16'h0);
        check_eq("illegal.mileage",   mileage, ODO ? 16'h0010 : 16'h0000);

        // Forced power-off event
        state  = 4'b1000;
        change = 1'b1;
        step(1);
        check_eq("fault.set",     16'(fault), 16'h1);
        check_eq("fault.mileage", mileage,    16'h0000);
        change   = 1'b0;
        state    = 4'b0001;
        move_cmd = 4'b0000;
        step(1);
        check_eq("fault.clear", 16'(fault), 16'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 9))
                0:       state = 4'($urandom);
                1:       state = 4'b0001;
                2:       state = 4'b1000;
                3, 4:    state = 4'b0010;
                default: state = 4'b0100;
            endcase
            if ($urandom_range(0, 3) == 0) move_cmd = 4'($urandom);
            change = ($urandom_range(0, 19) == 0);
            step(1);
        end
        change = 1'b0;

        // Asynchronous reset mid-blink with mileage 5
        state    = 4'b1000;
        move_cmd = 4'b0000;
        step(1);
        state    = 4'b0100;
        move_cmd = 4'b0001;
        run(40, 1);
        check_eq("areset.pre_mileage", mileage, ODO ? 16'h0005 : 16'h0000);
        state    = 4'b0010;
        move_cmd = 4'b0100;
        run(6, 1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("areset.led_left",  16'(led_left),  16'h0);
        check_eq("areset.led_right", 16'(led_right), 16'h0);
        check_eq("areset.fault",     16'(fault),     16'h0);
        check_eq("areset.mileage",   mileage,        16'h0000);
        model_reset();
        @(negedge clk);
        rst      = 1'b1;
        state    = 4'b0001;
        move_cmd = 4'b0000;
        run(3, 1);

        // Drive the odometer up to 9999, then one more mile wraps it
        state = 4'b1000;
        step(1);
        state    = 4'b0100;
        move_cmd = 4'b0001;
        run(9999 * MILE_DIV, 0);
        check_eq("wrap.at9999", mileage, ODO ? 16'h9999 : 16'h0000);
        run(MILE_DIV, 1);
        check_eq("wrap.to0000", mileage, 16'h0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/motion_indicator.md
MOTION_INDICATOR -- requirements
Module: motion_indicator

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 50_000_000, meaning clk cycles per turn-lamp half-period.
REQ-002 SHALL have parameter MILE_DIV, default 100_000_000, meaning clk cycles of motion per odometer count.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port state  input  4  one-hot drive state: 0001 unstarting, 0010 starting, 0100 moving, 1000 power_off.
REQ-007 SHALL have port move_cmd  input  4  motion command: [3] right, [2] left, [1] reverse, [0] forward.
REQ-008 SHALL have port change  input  1  forced-power-off event from the drive controller.
REQ-009 SHALL have port led_left  output  1  left turn lamp.
REQ-010 SHALL have port led_right  output  1  right turn lamp.
REQ-011 SHALL have port fault  output  1  latched forced-off indication.
REQ-012 SHALL have port mileage  output  16  odometer, 4 BCD digits, [15:12] most significant.

Function
REQ-013 SHALL run a blink prescaler counting 0..BLINK_DIV-1, wrapping to 0; terminal count toggles blink phase.
REQ-014 SHALL drive led_left = move_cmd[2] & phase, and led_right = move_cmd[3] & phase, when state is starting or moving; otherwise both 0. Outputs are registered, 1-cycle latency.
REQ-015 SHALL restart blinking on a rising edge of (move_cmd[2] | move_cmd[3]): prescaler cleared, phase set to 1. The lamp is lit on the next cycle.
REQ-016 SHALL run a mileage prescaler, 0..MILE_DIV-1, advancing only while state = moving and (move_cmd[0] | move_cmd[1]). The prescaler holds its value otherwise.
REQ-017 SHALL increment mileage by 1 in BCD on mileage prescaler terminal count; 9999 wraps to 0000; each digit 9 carries to 0.
REQ-018 SHALL hold mileage in unstarting and starting.
REQ-019 SHALL clear mileage and the mileage prescaler in any cycle with state = power_off.
REQ-020 SHALL set fault in the cycle after change = 1. Fault holds until state = unstarting is sampled. If change and unstarting occur together, set wins.
REQ-021 SHALL treat a non-one-hot state as power_off for the lamps (off). Mileage and fault SHALL hold in that case.

Reset
REQ-022 SHALL, on rst = 0, asynchronously force led_left = 0, led_right = 0, fault = 0, mileage = 16'h0000, both prescalers = 0, phase = 0.
REQ-023 SHALL resume operation on the first clk edge after rst deasserts. Reset mid-blink or mid-count discards partial counts.

Configuration
REQ-024 SHALL compile the odometer (REQ-016..019) only when ODOMETER_EN is defined.
REQ-025 SHALL tie mileage to 16'h0000 and instantiate no mileage logic without ODOMETER_EN. Lamps and fault are unaffected.

Structure
REQ-026 SHALL take the state encodings (ST_UNSTARTING, ST_STARTING, ST_MOVING, ST_POWER_OFF) and the move_cmd bit indices from shared package drive_pkg.
REQ-027 SHALL implement the 4-digit BCD counter with enable, synchronous clear and wrap as sub-module bcd4_counter.

Verification (BLINK_DIV=4, MILE_DIV=8, ODOMETER_EN defined)
REQ-028 SHALL check: state=0010, move_cmd=0100 from reset -> led_left=1 one cycle later, toggling every 4 cycles; led_right=0.
REQ-029 SHALL check: state=0100, move_cmd=0001 for 80 cycles -> mileage=0x0010. Then state=0010 for 20 cycles -> mileage stays 0x0010.
REQ-030 SHALL check: mileage preloaded to 0x9999 via motion, plus 8 more moving cycles -> mileage=0x0000.
REQ-031 SHALL check: change=1 for 1 cycle with state=1000 -> fault=1 next cycle and mileage=0x0000. Then state=0001 -> fault=0 next cycle.
REQ-032 SHALL check: rst pulsed low mid-blink with mileage=0x0005 -> all outputs 0 immediately, without waiting for a clk edge.
REQ-033 SHALL check: state=0110 (illegal) with move_cmd=1000 -> led_right=0, mileage holds.
